dbus_arbiter: RTL and testbench

//  Shares the single core data-bus port between two requesters: m0 = LSU, m1 = debug/DMA.

---
 rtl/dbus_arbiter.sv | 146 ++++++++++++++
 tb/tb_dbus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: round-robin grant with a stall lock, and read
// responses steered back to their issuer through an in-order owner FIFO.
module dbus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                io_m0_req_valid,
    output logic                io_m0_req_ready,
    input  logic [ADDR_W-1:0]   io_m0_req_bits_addr,
    input  logic [DATA_W-1:0]   io_m0_req_bits_wdata,
    input  logic                io_m0_req_bits_wen,
    input  logic [DATA_W/8-1:0] io_m0_req_bits_wstrb,
    output logic                io_m0_resp_valid,
    input  logic                io_m0_resp_ready,
    output logic [DATA_W-1:0]   io_m0_resp_bits,

    input  logic                io_m1_req_valid,
    output logic                io_m1_req_ready,
    input  logic [ADDR_W-1:0]   io_m1_req_bits_addr,
    input  logic [DATA_W-1:0]   io_m1_req_bits_wdata,
    input  logic                io_m1_req_bits_wen,
    input  logic [DATA_W/8-1:0] io_m1_req_bits_wstrb,
    output logic                io_m1_resp_valid,
    input  logic                io_m1_resp_ready,
    output logic [DATA_W-1:0]   io_m1_resp_bits,

    output logic                io_bus_req_valid,
    input  logic                io_bus_req_ready,
    output logic [ADDR_W-1:0]   io_bus_req_bits_addr,
    output logic [DATA_W-1:0]   io_bus_req_bits_wdata,
    output logic                io_bus_req_bits_wen,
    output logic [DATA_W/8-1:0] io_bus_req_bits_wstrb,
    input  logic                io_bus_resp_valid,
    output logic                io_bus_resp_ready,
    input  logic [DATA_W-1:0]   io_bus_resp_bits
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);

    logic                   lock;
    logic                   lock_id;
    logic                   rr_ptr;
    logic                   grant;
    logic                   g_valid;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   head;
    logic [OUTSTANDING-1:0] owner;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        grant = 1'b0;
        if (lock)
            grant = lock_id;
        else if (io_m0_req_valid && io_m1_req_valid)
            grant = rr_ptr;
        else if (io_m1_req_valid)
            grant = 1'b1;
    end

    assign g_valid               = grant ? io_m1_req_valid      : io_m0_req_valid;
    assign io_bus_req_bits_addr  = grant ? io_m1_req_bits_addr  : io_m0_req_bits_addr;
    assign io_bus_req_bits_wdata = grant ? io_m1_req_bits_wdata : io_m0_req_bits_wdata;
    assign io_bus_req_bits_wen   = grant ? io_m1_req_bits_wen   : io_m0_req_bits_wen;
    assign io_bus_req_bits_wstrb = grant ? io_m1_req_bits_wstrb : io_m0_req_bits_wstrb;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = owner[rd_ptr];

    // Only reads consume an owner slot, so only reads are held back by a full FIFO;
    // the full test deliberately ignores a pop happening in the same cycle.
    assign io_bus_req_valid = !reset && g_valid && !(!io_bus_req_bits_wen && full);
    assign accept           = io_bus_req_valid && io_bus_req_ready;
    assign io_m0_req_ready  = accept && !grant;
    assign io_m1_req_ready  = accept && grant;
    assign push             = accept && !io_bus_req_bits_wen;

    assign io_m0_resp_valid = !reset && !empty && io_bus_resp_valid && !head;
    assign io_m1_resp_valid = !reset && !empty && io_bus_resp_valid && head;
    assign io_m0_resp_bits  = io_bus_resp_bits;
    assign io_m1_resp_bits  = io_bus_resp_bits;

    // An unowned response is sunk rather than allowed to wedge the bus.
    always_comb begin
        io_bus_resp_ready = 1'b0;
        if (!reset)
            io_bus_resp_ready = empty ? 1'b1 : (head ? io_m1_resp_ready : io_m0_resp_ready);
    end

    assign pop = io_bus_resp_valid && io_bus_resp_ready && !empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_id <= 1'b0;
            rr_ptr  <= 1'b0;
            owner   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (accept) begin
                lock   <= 1'b0;
                rr_ptr <= ~grant;
            end else if (io_bus_req_valid) begin
                lock    <= 1'b1;
                lock_id <= grant;
            end
            if (push) begin
                owner[wr_ptr] <= grant;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_orphan_resp: assert property (@(posedge clock) disable iff (reset)
        !(io_bus_resp_valid && empty));

    a_locked_holds_valid: assert property (@(posedge clock) disable iff (reset)
        lock |-> (lock_id ? io_m1_req_valid : io_m0_req_valid));

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: arbitration order, stall lock, owner FIFO
// routing and full stall, write bypass, and reset while reads are in flight.
module tb_dbus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_ready;
    logic [31:0] m0_addr, m0_wdata, m0_resp_bits;
    logic [3:0]  m0_wstrb;
    logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready;
    logic [31:0] m1_addr, m1_wdata, m1_resp_bits;
    logic [3:0]  m1_wstrb;
    logic        bus_req_valid, bus_req_ready, bus_wen, bus_resp_valid, bus_resp_ready;
    logic [31:0] bus_addr, bus_wdata, bus_resp_bits;
    logic [3:0]  bus_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTSTANDING(2)) dut (
        .clock(clock), .reset(reset),
        .io_m0_req_valid(m0_req_valid), .io_m0_req_ready(m0_req_ready),
        .io_m0_req_bits_addr(m0_addr), .io_m0_req_bits_wdata(m0_wdata),
        .io_m0_req_bits_wen(m0_wen), .io_m0_req_bits_wstrb(m0_wstrb),
        .io_m0_resp_valid(m0_resp_valid), .io_m0_resp_ready(m0_resp_ready),
        .io_m0_resp_bits(m0_resp_bits),
        .io_m1_req_valid(m1_req_valid), .io_m1_req_ready(m1_req_ready),
        .io_m1_req_bits_addr(m1_addr), .io_m1_req_bits_wdata(m1_wdata),
        .io_m1_req_bits_wen(m1_wen), .io_m1_req_bits_wstrb(m1_wstrb),
        .io_m1_resp_valid(m1_resp_valid), .io_m1_resp_ready(m1_resp_ready),
        .io_m1_resp_bits(m1_resp_bits),
        .io_bus_req_valid(bus_req_valid), .io_bus_req_ready(bus_req_ready),
        .io_bus_req_bits_addr(bus_addr), .io_bus_req_bits_wdata(bus_wdata),
        .io_bus_req_bits_wen(bus_wen), .io_bus_req_bits_wstrb(bus_wstrb),
        .io_bus_resp_valid(bus_resp_valid), .io_bus_resp_ready(bus_resp_ready),
        .io_bus_resp_bits(bus_resp_bits)
    );

    task automatic idle_inputs;
        m0_req_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wen = 0; m0_wstrb = 0; m0_resp_ready = 0;
        m1_req_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wen = 0; m1_wstrb = 0; m1_resp_ready = 0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_resp_bits = 0;
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset;
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        m0_req_valid = 1; bus_req_ready = 1; bus_resp_valid = 1; m0_resp_ready = 1;
        @(negedge clock);
        n_checks++; if (bus_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_bus_req_valid: got %b want 0", bus_req_valid); end
        n_checks++; if (m0_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_m0_req_ready: got %b want 0", m0_req_ready); end
        n_checks++; if (bus_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_bus_resp_ready: got %b want 0", bus_resp_ready); end
        n_checks++; if (m0_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_m0_resp_valid: got %b want 0", m0_resp_valid); end
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_read;
        m0_req_valid = 1; m0_addr = 32'h100; m0_wen = 0; bus_req_ready = 1;
        @(negedge clock);
        n_checks++; if (bus_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_bus_req_valid: got %b want 1", bus_req_valid); end
        n_checks++; if (bus_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL t1_bus_addr: got %h want 00000100", bus_addr); end
        n_checks++; if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_req_ready: got m0=%b m1=%b want m0=1 m1=0", m0_req_ready, m1_req_ready); end
        next_cycle();
        m0_req_valid = 0;
        bus_resp_valid = 1; bus_resp_bits = 32'hDEADBEEF; m0_resp_ready = 1;
        @(negedge clock);
        n_checks++; if (m0_resp_valid !== 1'b1 || m0_resp_bits !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL t1_m0_resp: got v=%b d=%h want v=1 d=deadbeef", m0_resp_valid, m0_resp_bits); end
        n_checks++; if (m1_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_m1_resp_valid: got %b want 0", m1_resp_valid); end
        n_checks++; if (bus_resp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_bus_resp_ready: got %b want 1", bus_resp_ready); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_round_robin;
        int accepts = 0;
        m0_req_valid = 1; m0_addr = 32'hA0; m0_wen = 1; m0_wstrb = 4'hF;
        m1_req_valid = 1; m1_addr = 32'hB0; m1_wen = 1; m1_wstrb = 4'h3;
        bus_req_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic want_m0;
            want_m0 = (i % 2 == 0);
            @(negedge clock);
            if (bus_req_valid && bus_req_ready) accepts++;
            n_checks++; if (m0_req_ready !== want_m0 || m1_req_ready !== !want_m0) begin n_fail++; $display("[TB] FAIL t2_grant_%0d: got m0=%b m1=%b want m0=%b", i, m0_req_ready, m1_req_ready, want_m0); end
            n_checks++; if (bus_addr !== (want_m0 ? 32'hA0 : 32'hB0)) begin n_fail++; $display("[TB] FAIL t2_addr_%0d: got %h want %h", i, bus_addr, want_m0 ? 32'hA0 : 32'hB0); end
            next_cycle();
        end
        n_checks++; if (accepts !== 4) begin n_fail++; $display("[TB] FAIL t2_accepts: got %0d want 4", accepts); end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_lock;
        m1_req_valid = 1; m1_addr = 32'h200; m1_wdata = 32'hCAFE0001; m1_wen = 1; m1_wstrb = 4'hF;
        bus_req_ready = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin m0_req_valid = 1; m0_addr = 32'h204; m0_wdata = 32'h12345678; m0_wen = 1; m0_wstrb = 4'h1; end
            if (c == 3) bus_req_ready = 1;
            if (c == 4) m1_req_valid = 0;
            @(negedge clock);
            if (c < 4) begin
                n_checks++; if (bus_addr !== 32'h200 || bus_wdata !== 32'hCAFE0001) begin n_fail++; $display("[TB] FAIL t3_hold_%0d: got a=%h d=%h want a=00000200 d=cafe0001", c, bus_addr, bus_wdata); end
                n_checks++; if (m1_req_ready !== (c == 3) || m0_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL t3_ready_%0d: got m0=%b m1=%b want m0=0 m1=%b", c, m0_req_ready, m1_req_ready, c == 3); end
            end else begin
                n_checks++; if (m0_req_ready !== 1'b1 || bus_addr !== 32'h204) begin n_fail++; $display("[TB] FAIL t3_m0_after: got rdy=%b a=%h want rdy=1 a=00000204", m0_req_ready, bus_addr); end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_fifo_full;
        bus_req_ready = 1;
        m0_req_valid = 1; m0_addr = 32'h300; m0_wen = 0;
        @(negedge clock);
        n_checks++; if (m0_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_rd0_ready: got %b want 1", m0_req_ready); end
        next_cycle();
        m0_req_valid = 0; m1_req_valid = 1; m1_addr = 32'h304; m1_wen = 0;
        @(negedge clock);
        n_checks++; if (m1_req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_rd1_ready: got %b want 1", m1_req_ready); end
        next_cycle();
        m1_req_valid = 0; m0_req_valid = 1; m0_addr = 32'h308;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_checks++; if (bus_req_valid !== 1'b0 || m0_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_stall_%0d: got v=%b rdy=%b want v=0 rdy=0", c, bus_req_valid, m0_req_ready); end
            next_cycle();
        end
        bus_resp_valid = 1; bus_resp_bits = 32'h11; m0_resp_ready = 1;
        @(negedge clock);
        n_checks++; if (m0_resp_valid !== 1'b1 || m0_resp_bits !== 32'h11 || m1_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_resp0: got m0v=%b d=%h m1v=%b want 1 11 0", m0_resp_valid, m0_resp_bits, m1_resp_valid); end
        next_cycle();
        bus_resp_valid = 0;
        @(negedge clock);
        n_checks++; if (bus_req_valid !== 1'b1 || m0_req_ready !== 1'b1 || bus_addr !== 32'h308) begin n_fail++; $display("[TB] FAIL t4_issue3: got v=%b rdy=%b a=%h want 1 1 00000308", bus_req_valid, m0_req_ready, bus_addr); end
        next_cycle();
        m0_req_valid = 0; m1_resp_ready = 0;
        bus_resp_valid = 1; bus_resp_bits = 32'h22;
        @(negedge clock);
        n_checks++; if (bus_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_backpressure: got %b want 0", bus_resp_ready); end
        n_checks++; if (m1_resp_valid !== 1'b1 || m0_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_route1: got m0v=%b m1v=%b want 0 1", m0_resp_valid, m1_resp_valid); end
        next_cycle();
        m1_resp_ready = 1;
        @(negedge clock);
        n_checks++; if (m1_resp_bits !== 32'h22 || bus_resp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_resp1: got d=%h rr=%b want 22 1", m1_resp_bits, bus_resp_ready); end
        next_cycle();
        bus_resp_bits = 32'h33;
        @(negedge clock);
        n_checks++; if (m0_resp_valid !== 1'b1 || m1_resp_valid !== 1'b0 || m0_resp_bits !== 32'h33) begin n_fail++; $display("[TB] FAIL t4_resp2: got m0v=%b m1v=%b d=%h want 1 0 33", m0_resp_valid, m1_resp_valid, m0_resp_bits); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_write_no_queue;
        bus_req_ready = 1;
        m0_req_valid = 1; m0_addr = 32'h400; m0_wen = 0;
        next_cycle();
        m0_req_valid = 0;
        m1_req_valid = 1; m1_addr = 32'h404; m1_wen = 1; m1_wdata = 32'hBEEF; m1_wstrb = 4'hC;
        @(negedge clock);
        n_checks++; if (m1_req_ready !== 1'b1 || bus_wen !== 1'b1 || bus_wstrb !== 4'hC) begin n_fail++; $display("[TB] FAIL t5_write: got rdy=%b wen=%b strb=%h want 1 1 c", m1_req_ready, bus_wen, bus_wstrb); end
        next_cycle();
        m1_req_valid = 0;
        bus_resp_valid = 1; bus_resp_bits = 32'h55; m0_resp_ready = 1;
        @(negedge clock);
        n_checks++; if (m0_resp_valid !== 1'b1 || m0_resp_bits !== 32'h55 || m1_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t5_resp: got m0v=%b d=%h m1v=%b want 1 55 0", m0_resp_valid, m0_resp_bits, m1_resp_valid); end
        next_cycle();
        idle_inputs();
        @(negedge clock);
        n_checks++; if (bus_resp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL t5_empty: got %b want 1", bus_resp_ready); end
        next_cycle();
    endtask

    task automatic test_reset_midflight;
        bus_req_ready = 1;
        m0_req_valid = 1; m0_addr = 32'h500; m0_wen = 0;
        next_cycle();
        m0_req_valid = 0; m1_req_valid = 1; m1_addr = 32'h504; m1_wen = 0;
        next_cycle();
        m1_req_valid = 0; m0_req_valid = 1; m0_addr = 32'h508;
        bus_resp_valid = 1; bus_resp_bits = 32'h66; m0_resp_ready = 1;
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (bus_req_valid !== 1'b0 || m0_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_rst_req: got v=%b rdy=%b want 0 0", bus_req_valid, m0_req_ready); end
        n_checks++; if (m0_resp_valid !== 1'b0 || bus_resp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_rst_resp: got v=%b rr=%b want 0 0", m0_resp_valid, bus_resp_ready); end
        next_cycle();
        reset = 1'b0;
        bus_resp_valid = 0; m0_resp_ready = 0;
        m1_req_valid = 1; m1_addr = 32'h50C; m1_wen = 0;
        @(negedge clock);
        n_checks++; if (bus_req_valid !== 1'b1 || m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_after: got v=%b m0=%b m1=%b want 1 1 0", bus_req_valid, m0_req_ready, m1_req_ready); end
        n_checks++; if (bus_resp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL t6_flushed: got %b want 1", bus_resp_ready); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_single_read();
        pulse_reset();
        test_round_robin();
        test_lock();
        pulse_reset();
        test_fifo_full();
        test_write_no_queue();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
